// File: rtl/pixel_stream_packer_pkg.sv
// Shared definitions for the pixel stream packer.
//   state_t      : packer FSM states (IDLE / ACTIVE / DONE)
//   PIX_W        : width of one input pixel
//   WORD_W       : width of one packed output word
//   PIX_PER_WORD : pixels packed into one output word
package pixel_stream_packer_pkg;

  localparam int PIX_W        = 8;
  localparam int WORD_W       = 32;
  localparam int PIX_PER_WORD = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

endpackage

// File: rtl/packer_word_fifo.sv
// Synchronous word FIFO carrying data plus sof/eol tags.
// Ports:
//   sclk, rst_n        : clock (rising edge), asynchronous active-low reset
//   push_i, wdata_i,
//   wsof_i, weol_i     : write side; a push is taken when not full, or when
//                        full and a pop happens in the same cycle
//   pop_i              : read side; ignored while empty
//   rdata_o, rsof_o,
//   reol_o             : head entry, forced to 0 while empty
//   full_o, empty_o    : occupancy flags
module packer_word_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 32
) (
  input  logic         sclk,
  input  logic         rst_n,
  input  logic         push_i,
  input  logic [W-1:0] wdata_i,
  input  logic         wsof_i,
  input  logic         weol_i,
  input  logic         pop_i,
  output logic [W-1:0] rdata_o,
  output logic         rsof_o,
  output logic         reol_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int AW = $clog2(DEPTH);

  typedef struct packed {
    logic         sof;
    logic         eol;
    logic [W-1:0] data;
  } entry_t;

  entry_t      mem_q [DEPTH];
  entry_t      rd_entry;
  logic [AW:0] wr_ptr_q, rd_ptr_q;
  logic        do_push, do_pop;

  // Pointers carry one extra wrap bit to tell full from empty.
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  assign do_pop  = pop_i && !empty_o;
  // A pop in the same cycle frees the slot, so a full FIFO still takes the push.
  assign do_push = push_i && (!full_o || do_pop);

  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge sclk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= '{sof: wsof_i, eol: weol_i, data: wdata_i};
  end

  // Outputs are gated by empty so stale storage never shows, and so the
  // read side is all-zero straight out of reset.
  assign rd_entry = mem_q[rd_ptr_q[AW-1:0]];
  assign rdata_o  = empty_o ? '0   : rd_entry.data;
  assign rsof_o   = empty_o ? 1'b0 : rd_entry.sof;
  assign reol_o   = empty_o ? 1'b0 : rd_entry.eol;

endmodule

// File: rtl/pixel_stream_packer.sv
// Packs a stream of 8-bit pixels into 32-bit little-endian words (first pixel
// of a group in [7:0]) and queues them with frame/line tags for a downstream
// frame-buffer writer.
// Optional feature: define PACKER_OVF_CNT_EN to add the ovf_cnt port.
// Ports:
//   sclk, rst_n     : clock (rising edge), asynchronous active-low reset
//   pi_data/pi_flag : pixel input; pi_flag=0 cycles change nothing
//   out_ready       : downstream accepts the presented word
//   out_data/out_valid/out_sof/out_eol : packed word and its tags
//   frame_done      : one-cycle pulse after the last word of a frame is pushed
//   overflow        : sticky, a completed word was dropped on a full FIFO
//   ovf_cnt         : saturating count of dropped words (optional)
//   dbg_state_o     : current FSM state
// Handshake: a word transfers on a rising edge where out_valid=1 and
// out_ready=1; while out_valid=1 and out_ready=0 out_data/out_sof/out_eol hold.
module pixel_stream_packer
  import pixel_stream_packer_pkg::*;
#(
  parameter int COL_NUM    = 320,
  parameter int ROW_NUM    = 720,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              sclk,
  input  logic              rst_n,
  input  logic [PIX_W-1:0]  pi_data,
  input  logic              pi_flag,
  input  logic              out_ready,
  output logic [WORD_W-1:0] out_data,
  output logic              out_valid,
  output logic              out_sof,
  output logic              out_eol,
  output logic              frame_done,
  output logic              overflow,
`ifdef PACKER_OVF_CNT_EN
  output logic [15:0]       ovf_cnt,
`endif
  output state_t            dbg_state_o
);

  localparam int COL_W  = (COL_NUM > 1) ? $clog2(COL_NUM) : 1;
  localparam int ROW_W  = (ROW_NUM > 1) ? $clog2(ROW_NUM) : 1;
  localparam int PACK_W = PIX_W * (PIX_PER_WORD - 1);

  logic [COL_W-1:0]  col_d, col_q;
  logic [ROW_W-1:0]  row_d, row_q;
  logic [PACK_W-1:0] pack_d, pack_q;
  logic              ovf_d, ovf_q;
  state_t            state_d, state_q;

  logic [1:0]        lane;
  logic              col_last, row_last;
  logic              word_done, frame_last;
  logic              word_sof, word_eol;
  logic [WORD_W-1:0] word;
  logic              fifo_pop, fifo_full, fifo_empty, drop;

  // COL_NUM is a multiple of 4, so the low column bits are the lane index.
  assign lane       = col_q[1:0];
  assign col_last   = (col_q == COL_W'(COL_NUM - 1));
  assign row_last   = (row_q == ROW_W'(ROW_NUM - 1));
  assign word_done  = pi_flag && (lane == 2'(PIX_PER_WORD - 1));
  assign frame_last = word_done && col_last && row_last;

  // Tags are evaluated when the 4th pixel arrives: the sof word ends at
  // (row 0, col 3) and the eol word ends at the last column.
  assign word_sof   = (row_q == '0) && (col_q == COL_W'(PIX_PER_WORD - 1));
  assign word_eol   = col_last;
  assign word       = {pi_data, pack_q};

  assign fifo_pop   = out_valid && out_ready;
  // Dropped words still advance the counters; only the FIFO write is lost.
  assign drop       = word_done && fifo_full && !fifo_pop;

  // Column/row counters and pack register.
  always_comb begin
    col_d  = col_q;
    row_d  = row_q;
    pack_d = pack_q;
    if (pi_flag) begin
      if (col_last) begin
        col_d = '0;
        row_d = row_last ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
      if (lane != 2'd3) pack_d[lane*PIX_W +: PIX_W] = pi_data;
    end
  end

  assign ovf_d = ovf_q | drop;

  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      col_q  <= '0;
      row_q  <= '0;
      pack_q <= '0;
      ovf_q  <= 1'b0;
    end else begin
      col_q  <= col_d;
      row_q  <= row_d;
      pack_q <= pack_d;
      ovf_q  <= ovf_d;
    end
  end

`ifdef PACKER_OVF_CNT_EN
  logic [15:0] ovf_cnt_q;

  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n)                        ovf_cnt_q <= '0;
    else if (drop && ovf_cnt_q != '1)  ovf_cnt_q <= ovf_cnt_q + 1'b1;
  end

  assign ovf_cnt = ovf_cnt_q;
`endif

  // FSM: state register.
  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // FSM: next state. A pixel arriving in DONE is pixel (0,0) of the next frame.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (pi_flag) state_d = ST_ACTIVE;
      ST_ACTIVE: if (frame_last) state_d = ST_DONE;
      ST_DONE:   state_d = pi_flag ? ST_ACTIVE : ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // FSM: outputs.
  always_comb begin
    frame_done = (state_q == ST_DONE);
  end

  assign dbg_state_o = state_q;

  packer_word_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (WORD_W)
  ) u_fifo (
    .sclk    (sclk),
    .rst_n   (rst_n),
    .push_i  (word_done),
    .wdata_i (word),
    .wsof_i  (word_sof),
    .weol_i  (word_eol),
    .pop_i   (fifo_pop),
    .rdata_o (out_data),
    .rsof_o  (out_sof),
    .reol_o  (out_eol),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign out_valid = !fifo_empty;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_pixel_stream_packer.sv
// Bench for pixel_stream_packer with an 8x2 frame and a 4-deep word FIFO.
// A pixel-level reference model tracks frame position, packed words, FIFO
// occupancy, drops and frame completion; a monitor compares DUT outputs
// against it every cycle.
module tb_pixel_stream_packer;
  import pixel_stream_packer_pkg::*;

  localparam int COLS      = 8;
  localparam int ROWS      = 2;
  localparam int DEPTH     = 4;
  localparam int FRAME_PIX = COLS * ROWS;

  // ---------------- clock / reset / DUT ----------------
  logic        sclk      = 1'b0;
  logic        rst_n     = 1'b1;
  logic [7:0]  pi_data   = '0;
  logic        pi_flag   = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
  logic        out_valid, out_sof, out_eol, frame_done, overflow;
  state_t      dbg_state;
`ifdef PACKER_OVF_CNT_EN
  logic [15:0] ovf_cnt;
  int          m_ovf_cnt = 0;
`endif

  always #5 sclk = ~sclk;

  pixel_stream_packer #(
    .COL_NUM    (COLS),
    .ROW_NUM    (ROWS),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .sclk        (sclk),
    .rst_n       (rst_n),
    .pi_data     (pi_data),
    .pi_flag     (pi_flag),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_sof     (out_sof),
    .out_eol     (out_eol),
    .frame_done  (frame_done),
    .overflow    (overflow),
`ifdef PACKER_OVF_CNT_EN
    .ovf_cnt     (ovf_cnt),
`endif
    .dbg_state_o (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [33:0] exp_q[$];       // {sof, eol, data} of every word the DUT must deliver
  int          m_occ = 0;      // words held in the FIFO
  int          m_n   = 0;      // pixel index within the frame
  logic [31:0] m_acc = '0;
  logic        m_ovf  = 1'b0;
  logic        m_done = 1'b0;

  task automatic check(input string name, input logic [33:0] act, input logic [33:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: actual=%h required=%h @%0t", name, act, req, $time);
    end
  endtask

  function automatic void model_clear();
    exp_q.delete();
    m_occ  = 0;
    m_n    = 0;
    m_acc  = '0;
    m_ovf  = 1'b0;
    m_done = 1'b0;
`ifdef PACKER_OVF_CNT_EN
    m_ovf_cnt = 0;
`endif
  endfunction

  // Reference model: frame position from the pixel index, a word every 4th
  // accepted pixel, dropped when the FIFO holds DEPTH words and none leaves.
  always @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      model_clear();
    end else begin
      int idx, col, row;
      m_done = 1'b0;
      if (m_occ > 0 && out_ready) m_occ--;
      if (pi_flag) begin
        idx = m_n % 4;
        col = m_n % COLS;
        row = m_n / COLS;
        m_acc[idx*8 +: 8] = pi_data;
        if (idx == 3) begin
          if (m_occ == DEPTH) begin
            m_ovf = 1'b1;
`ifdef PACKER_OVF_CNT_EN
            if (m_ovf_cnt < 65535) m_ovf_cnt++;
`endif
          end else begin
            m_occ++;
            exp_q.push_back({(row == 0 && col == 3), (col == COLS - 1), m_acc});
          end
          if (row == ROWS - 1 && col == COLS - 1) m_done = 1'b1;
        end
        m_n = (m_n + 1) % FRAME_PIX;
      end
    end
  end

  // Monitor: compares on the falling edge, away from the active edge.
  always @(negedge sclk) begin
    if (rst_n) begin
      check("out_valid", out_valid, (m_occ > 0));
      check("overflow", overflow, m_ovf);
      check("frame_done", frame_done, m_done);
`ifdef PACKER_OVF_CNT_EN
      check("ovf_cnt", ovf_cnt, m_ovf_cnt);
`endif
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL word_unexpected: actual=%h required=none @%0t", out_data, $time);
        end else begin
          // Checked every valid cycle, so a stalled word must also hold steady.
          check("word", {out_sof, out_eol, out_data}, exp_q[0]);
          if (out_ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive_cycle(input logic flag, input logic [7:0] d, input logic rdy);
    pi_flag   = flag;
    pi_data   = d;
    out_ready = rdy;
    @(posedge sclk);
    #2;
  endtask

  task automatic do_reset();
    pi_flag   = 1'b0;
    out_ready = 1'b0;
    rst_n     = 1'b0;
    #1;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_data", out_data, 32'h0);
    check("rst_out_sof", out_sof, 1'b0);
    check("rst_out_eol", out_eol, 1'b0);
    check("rst_frame_done", frame_done, 1'b0);
    check("rst_overflow", overflow, 1'b0);
    check("rst_state", dbg_state, ST_IDLE);
`ifdef PACKER_OVF_CNT_EN
    check("rst_ovf_cnt", ovf_cnt, 16'h0);
`endif
    @(posedge sclk);
    @(posedge sclk);
    #2;
    rst_n = 1'b1;
  endtask

  task automatic send_pixels(input int count, input int base, input logic rdy, input bit gaps);
    for (int i = 0; i < count; i++) begin
      drive_cycle(1'b1, 8'(base + i), rdy);
      if (gaps) drive_cycle(1'b0, 8'($urandom_range(0, 255)), rdy);
    end
  endtask

  task automatic stall(input int cycles);
    for (int i = 0; i < cycles; i++) drive_cycle(1'b0, 8'($urandom_range(0, 255)), 1'b0);
  endtask

  task automatic drain(input int max_cycles);
    int k = 0;
    pi_flag   = 1'b0;
    out_ready = 1'b1;
    while ((m_occ > 0 || exp_q.size() > 0) && k < max_cycles) begin
      @(posedge sclk);
      #2;
      k++;
    end
    if (m_occ > 0 || exp_q.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain_timeout: actual=%0d words left required=0", exp_q.size());
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    #2;
    do_reset();

    // Continuous frame, always ready: 03020100 sof, 07060504 eol, 0B0A0908, 0F0E0D0C eol.
    send_pixels(16, 0, 1'b1, 1'b0);
    drain(20);

    // Same frame with blanking between every pixel.
    send_pixels(16, 0, 1'b1, 1'b1);
    drain(20);

    // Full frame into a stalled downstream: FIFO fills, nothing dropped,
    // words held while stalled, then drained in order.
    send_pixels(16, 8'h40, 1'b0, 1'b0);
    stall(5);
    drain(20);

    // A fifth word on a full FIFO is dropped; it carries the next frame's sof.
    send_pixels(20, 8'h80, 1'b0, 1'b0);
    stall(2);
    drain(20);
    send_pixels(12, 8'hA0, 1'b1, 1'b0);
    send_pixels(16, 8'hC0, 1'b1, 1'b0);
    drain(20);

    // Full FIFO with push and pop on the same edge: no drop, stays full.
    do_reset();
    send_pixels(16, 8'h10, 1'b0, 1'b0);
    send_pixels(3, 8'h20, 1'b0, 1'b0);
    drive_cycle(1'b1, 8'h23, 1'b1);
    stall(3);
    drain(20);

    // Reset in the middle of a frame: partial word discarded, restart at (0,0).
    send_pixels(6, 8'h60, 1'b1, 1'b0);
    do_reset();
    send_pixels(4, 8'h70, 1'b1, 1'b0);
    drain(20);

    // Randomized traffic with blanking and stalls.
    for (int i = 0; i < 3000; i++) begin
      drive_cycle(($urandom_range(0, 3) != 0), 8'($urandom_range(0, 255)),
                  ($urandom_range(0, 9) > 3));
    end
    drain(40);

    check("leftover_words", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
